ps_astat_reg: RTL
=================

// Module: ps_astat_reg
// PURPOSE
//  Arithmetic status (ASTAT) register and status stack for the processor core. Producer of the
//  8-bit astat_bts vector consumed by the condition decoder (cnd_stat evaluation).
//  Collects per-cycle flags from the ALU, multiplier and shifter; supports explicit universal-
//  register (ureg) read/write and push/pop of ASTAT on a small status stack (call/interrupt).
// PARAMETERS
//  STS_DEPTH  4   status stack depth in entries (>=2); pointer width = $clog2(STS_DEPTH+1)
//  DATA_W     16  ureg data bus width (>=8)
// PORTS
//  clk          in   1       core clock, all state on rising edge
//  reset        in   1       synchronous, active-high reset
//  alu_flg_en   in   1       ALU flag update strobe
//  alu_flg      in   4       {AC,AN,AV,AZ} -> astat_bts[3],[2],[1],[0]
//  mul_flg_en   in   1       multiplier flag update strobe
//  mul_flg      in   2       {MV,MN} -> astat_bts[5],[4]
//  shf_flg_en   in   1       shifter flag update strobe
//  shf_flg      in   2       {SZ,SV} -> astat_bts[7],[6]
//  ureg_wr_en   in   1       ureg write to status register
//  ureg_sel     in   1       0 = ASTAT, 1 = STKY (STKY only with PS_ASTAT_STKY_EN)
//  ureg_din     in   DATA_W  write data; [7:0] used, upper bits ignored
//  ureg_dout    out  DATA_W  combinational read of selected register, zero-extended
//  sts_push     in   1       push current ASTAT onto status stack
//  sts_pop      in   1       pop top of stack into ASTAT
//  astat_bts    out  8       registered ASTAT: {SZ,SV,MV,MN,AC,AN,AV,AZ}
//  stky_bts     out  3       {SVS,MVS,AVS} sticky overflow; 3'b000 when feature compiled out
//  sts_empty    out  1       stack holds 0 entries
//  sts_full     out  1       stack holds STS_DEPTH entries
//  sts_err      out  1       sticky: push-when-full, pop-when-empty, or push&pop same cycle
// BEHAVIOUR
//  - Reset: astat_bts=0, stky_bts=0, stack pointer=0 (sts_empty=1, sts_full=0), sts_err=0.
//  - Latency: every update lands on the next rising edge; astat_bts is never bypassed, so the
//    condition decoder sees the pre-update value in the cycle the strobe is asserted.
//  - ASTAT next-value priority (high->low): reset; ureg write with ureg_sel=0 (all 8 bits);
//    valid sts_pop (all 8 bits from top entry); per-field unit updates. ALU, MUL, SHF fields are
//    disjoint, so any combination of the three strobes updates its own fields in the same cycle.
//  - A lower-priority source is fully discarded when a higher one writes ASTAT that cycle.
//  - Stack: push stores the registered astat_bts (pre-update value of this cycle), ptr+1.
//    Pop loads entry ptr-1 into ASTAT, ptr-1. Entries are not cleared on pop.
//  - Push when full: dropped, ptr unchanged, sts_err<=1. Pop when empty: ASTAT follows the
//    lower-priority sources as if no pop, ptr unchanged, sts_err<=1.
//  - Push and pop same cycle: both ignored (ptr and stack unchanged, no ASTAT load), sts_err<=1.
//  - sts_err clears only on reset. sts_full/sts_empty decode the registered pointer.
//  - ureg_dout: ureg_sel=0 -> {0,astat_bts}; ureg_sel=1 -> {0,stky_bts}; reflects register state,
//    not same-cycle writes.
// CONFIGURATION
//  PS_ASTAT_STKY_EN defined: STKY register present. Each cycle AVS|=(alu_flg_en&alu_flg[1]),
//    MVS|=(mul_flg_en&mul_flg[1]), SVS|=(shf_flg_en&shf_flg[0]). Sticky bits are not stacked,
//    not affected by pop. ureg write with ureg_sel=1 loads ureg_din[2:0] and wins over the
//    same-cycle OR-in.
//  Not defined: no STKY storage; stky_bts=0; ureg write with ureg_sel=1 ignored; read returns 0.
// TESTING
//  1 reset, alu_flg_en=1 alu_flg=4'b0101 -> astat_bts=8'h05 next cycle, 8'h00 in strobe cycle.
//  2 ALU 4'b0001, MUL 2'b10, SHF 2'b01 together -> astat_bts=8'h61; then ureg_wr_en sel=0
//    din=16'h00A0 with alu strobe -> astat_bts=8'hA0.
//  3 push 8'h61, push 8'hA0, write 8'h00, pop -> 8'hA0, pop -> 8'h61, sts_empty=1, sts_err=0.
//  4 STS_DEPTH pushes -> sts_full=1; extra push -> sts_err=1, later pops return first
//    STS_DEPTH values; pop on empty with alu 4'b0001 -> astat_bts=8'h01.
//  5 push&pop same cycle with 1 entry -> ptr unchanged, astat_bts unchanged, sts_err=1.
//  6 STKY_EN: alu_flg=4'b0010 one cycle then 4'b0000 -> astat AV=0, stky_bts=3'b001 holds;
//    ureg write sel=1 din=0 -> stky_bts=0; compiled out -> stky_bts stays 0, ureg_dout=0.

Source files
------------

// File: rtl/ps_astat_reg.sv
// ps_astat_reg: arithmetic status (ASTAT) register with a small status stack.
// Collects ALU/MUL/SHF flags. Supports ureg read/write and push/pop of ASTAT.
// Optional sticky overflow register (STKY) is enabled by defining PS_ASTAT_STKY_EN.
module ps_astat_reg #(
  parameter int STS_DEPTH = 4,
  parameter int DATA_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_flg_en,
  input  logic [3:0]        alu_flg,
  input  logic              mul_flg_en,
  input  logic [1:0]        mul_flg,
  input  logic              shf_flg_en,
  input  logic [1:0]        shf_flg,
  input  logic              ureg_wr_en,
  input  logic              ureg_sel,
  input  logic [DATA_W-1:0] ureg_din,
  output logic [DATA_W-1:0] ureg_dout,
  input  logic              sts_push,
  input  logic              sts_pop,
  output logic [7:0]        astat_bts,
  output logic [2:0]        stky_bts,
  output logic              sts_empty,
  output logic              sts_full,
  output logic              sts_err
);

  localparam int PTR_W = $clog2(STS_DEPTH + 1);
  localparam int IDX_W = (STS_DEPTH > 1) ? $clog2(STS_DEPTH) : 1;

  logic [PTR_W-1:0] sts_ptr;
  logic [PTR_W-1:0] top_ptr;
  logic [7:0]       sts_mem [STS_DEPTH];
  logic [7:0]       astat_nxt;
  logic             push_ok;
  logic             pop_ok;
  logic             err_set;
  logic             astat_wr;
  logic             unused_din_bits;

  // Only the low byte of the ureg bus carries status bits.
  assign unused_din_bits = ^ureg_din[DATA_W-1:8];

  assign top_ptr   = sts_ptr - PTR_W'(1);
  assign sts_empty = (sts_ptr == '0);
  assign sts_full  = (sts_ptr == PTR_W'(STS_DEPTH));
  assign astat_wr  = ureg_wr_en & ~ureg_sel;

  // A simultaneous push and pop cancels both operations; overflow and underflow are dropped.
  assign push_ok = sts_push & ~sts_pop & ~sts_full;
  assign pop_ok  = sts_pop & ~sts_push & ~sts_empty;
  assign err_set = (sts_push & sts_pop) | (sts_push & ~sts_pop & sts_full)
                 | (sts_pop & ~sts_push & sts_empty);

  // Next ASTAT value: ureg write beats a valid pop, which beats the per-unit field updates.
  always_comb begin
    astat_nxt = astat_bts;
    if (astat_wr) begin
      astat_nxt = ureg_din[7:0];
    end else if (pop_ok) begin
      astat_nxt = sts_mem[top_ptr[IDX_W-1:0]];
    end else begin
      if (alu_flg_en) astat_nxt[3:0] = alu_flg;
      if (mul_flg_en) astat_nxt[5:4] = mul_flg;
      if (shf_flg_en) astat_nxt[7:6] = shf_flg;
    end
  end

  // ASTAT, stack pointer and the sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      astat_bts <= '0;
      sts_ptr   <= '0;
      sts_err   <= 1'b0;
    end else begin
      astat_bts <= astat_nxt;
      if (push_ok) sts_ptr <= sts_ptr + PTR_W'(1);
      else if (pop_ok) sts_ptr <= top_ptr;
      if (err_set) sts_err <= 1'b1;
    end
  end

  // Stack storage captures the pre-update ASTAT; entries are left intact on pop.
  always_ff @(posedge clk) begin
    if (push_ok) sts_mem[sts_ptr[IDX_W-1:0]] <= astat_bts;
  end

`ifdef PS_ASTAT_STKY_EN
  logic [2:0] stky_q;

  // Sticky overflows accumulate each cycle; an explicit ureg write overrides the OR-in.
  always_ff @(posedge clk) begin
    if (reset) begin
      stky_q <= '0;
    end else if (ureg_wr_en && ureg_sel) begin
      stky_q <= ureg_din[2:0];
    end else begin
      stky_q <= stky_q | {shf_flg_en & shf_flg[0], mul_flg_en & mul_flg[1], alu_flg_en & alu_flg[1]};
    end
  end

  assign stky_bts = stky_q;
`else
  assign stky_bts = 3'b000;
`endif

  // Read path shows register state only, never same-cycle write data.
  always_comb begin
    ureg_dout = {{(DATA_W-8){1'b0}}, astat_bts};
    if (ureg_sel) ureg_dout = {{(DATA_W-3){1'b0}}, stky_bts};
  end

endmodule
